// File: rtl/counter_sched.sv
// Two-requester scheduler sharing one interval counter; the owner gets gnt for len+2 cycles ending in a done pulse.
// Optional COUNTER_SCHED_RR_EN selects round-robin tie-break; default is fixed priority to requester 0.
module counter_sched #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_tc;
    logic [WIDTH-1:0] w_tc_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic             r_owner;
    logic             w_owner_nxt;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic             r_busy;
    logic             w_gnt0_nxt;
    logic             w_gnt1_nxt;
    logic             w_done0_nxt;
    logic             w_done1_nxt;
    logic             w_busy_nxt;
    logic             w_any_req;
    logic             w_win;
    logic             w_owner_req;
    logic             w_at_tc;

`ifdef COUNTER_SCHED_RR_EN
    logic             r_last;
`endif

    assign w_any_req   = req0 | req1;
    assign w_owner_req = r_owner ? req1 : req0;
    assign w_at_tc     = (r_out == r_tc);

    // Winner index: 0 = requester 0, 1 = requester 1
    always_comb begin
        w_win = 1'b0;
        if (req0 && req1) begin
`ifdef COUNTER_SCHED_RR_EN
            w_win = ~r_last;
`else
            w_win = 1'b0;
`endif
        end else if (req1) begin
            w_win = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_tc    <= '0;
            r_out   <= '0;
            r_owner <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tc    <= w_tc_nxt;
            r_out   <= w_out_nxt;
            r_owner <= w_owner_nxt;
            r_gnt0  <= w_gnt0_nxt;
            r_gnt1  <= w_gnt1_nxt;
            r_done0 <= w_done0_nxt;
            r_done1 <= w_done1_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef COUNTER_SCHED_RR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (r_state == IDLE && w_any_req) begin
            r_last <= w_win;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // Abort outranks completion: a dropped request never sees done
                if (!w_owner_req) begin
                    w_state_nxt = IDLE;
                end else if (w_at_tc) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_tc_nxt    = r_tc;
        w_out_nxt   = r_out;
        w_owner_nxt = r_owner;
        w_gnt0_nxt  = r_gnt0;
        w_gnt1_nxt  = r_gnt1;
        w_done0_nxt = 1'b0;
        w_done1_nxt = 1'b0;
        w_busy_nxt  = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                w_out_nxt  = '0;
                w_gnt0_nxt = 1'b0;
                w_gnt1_nxt = 1'b0;
                if (w_any_req) begin
                    w_tc_nxt    = w_win ? len1 : len0;
                    w_owner_nxt = w_win;
                    w_gnt0_nxt  = ~w_win;
                    w_gnt1_nxt  = w_win;
                end
            end
            RUN: begin
                if (!w_owner_req) begin
                    w_out_nxt  = '0;
                    w_gnt0_nxt = 1'b0;
                    w_gnt1_nxt = 1'b0;
                end else if (w_at_tc) begin
                    w_done0_nxt = ~r_owner;
                    w_done1_nxt = r_owner;
                end else begin
                    w_out_nxt = r_out + WIDTH'(1);
                end
            end
            DONE: begin
                w_out_nxt  = '0;
                w_gnt0_nxt = 1'b0;
                w_gnt1_nxt = 1'b0;
            end
            default: begin
                w_out_nxt  = '0;
                w_gnt0_nxt = 1'b0;
                w_gnt1_nxt = 1'b0;
            end
        endcase
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign done0 = r_done0;
    assign done1 = r_done1;
    assign busy  = r_busy;
    assign out   = r_out;

endmodule

// File: tb/tb_counter_sched.sv
// Directed-vector bench for counter_sched; expected values are hand-computed per cycle.
// Compile with COUNTER_SCHED_RR_EN defined to check round-robin tie ordering.
module tb_counter_sched;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             req0;
    logic [WIDTH-1:0] len0;
    logic             req1;
    logic [WIDTH-1:0] len1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic             busy;
    logic [WIDTH-1:0] out;

    int unsigned n_checks;
    int unsigned n_fail;

    counter_sched #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .len0  (len0),
        .req1  (req1),
        .len1  (len1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .busy  (busy),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status vector is {gnt0, gnt1, done0, done1, busy}
    task automatic expect_cyc(input string tag, input logic [4:0] st, input logic [WIDTH-1:0] o);
        check({tag, ".st"}, {27'd0, gnt0, gnt1, done0, done1, busy}, {27'd0, st});
        check({tag, ".out"}, {28'd0, out}, {28'd0, o});
    endtask

    logic [WIDTH-1:0] exp_out [5];
    int unsigned      cnt;
    logic             exp_own [3];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        len0 = '0;
        len1 = '0;

        // Reset held two cycles
        tick();
        tick();
        expect_cyc("reset", 5'b00000, 4'd0);

        // Basic interval, request present at first edge out of reset
        rst  = 1'b1;
        req0 = 1'b1;
        len0 = 4'd3;
        exp_out = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_cyc($sformatf("basic%0d", i), (i == 4) ? 5'b10101 : 5'b10001, exp_out[i]);
        end
        req0 = 1'b0;
        tick();
        expect_cyc("basic_end", 5'b00000, 4'd0);

        // Zero length
        req1 = 1'b1;
        len1 = 4'd0;
        tick();
        expect_cyc("zero0", 5'b01001, 4'd0);
        tick();
        expect_cyc("zero1", 5'b01011, 4'd0);
        req1 = 1'b0;
        tick();
        expect_cyc("zero_end", 5'b00000, 4'd0);

        // Tie, both requests held across completions
`ifdef COUNTER_SCHED_RR_EN
        exp_own = '{1'b0, 1'b1, 1'b0};
`else
        exp_own = '{1'b0, 1'b0, 1'b0};
`endif
        req0 = 1'b1;
        req1 = 1'b1;
        len0 = 4'd2;
        len1 = 4'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("tie%0d.gnt", k), {30'd0, gnt0, gnt1},
                  exp_own[k] ? 32'd1 : 32'd2);
            cnt = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                cnt++;
                if (done0 || done1) break;
            end
            check($sformatf("tie%0d.len", k), cnt, 32'd3);
            check($sformatf("tie%0d.done", k), {30'd0, done0, done1},
                  exp_own[k] ? 32'd1 : 32'd2);
            if (k == 2) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
            expect_cyc($sformatf("tie%0d.idle", k), 5'b00000, 4'd0);
        end

        // Abort when out reaches 4
        req0 = 1'b1;
        len0 = 4'd9;
        tick();
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (out == 4'd4) break;
            tick();
            cnt++;
        end
        check("abort.reach", cnt, 32'd4);
        expect_cyc("abort.pre", 5'b10001, 4'd4);
        req0 = 1'b0;
        tick();
        expect_cyc("abort.post", 5'b00000, 4'd0);
        tick();
        expect_cyc("abort.quiet", 5'b00000, 4'd0);

        // Reset during run at out=7
        req1 = 1'b1;
        len1 = 4'd15;
        tick();
        for (int c = 0; c < 20; c++) begin
            if (out == 4'd7) break;
            tick();
        end
        expect_cyc("rstrun.pre", 5'b01001, 4'd7);
        rst = 1'b0;
        tick();
        expect_cyc("rstrun.post", 5'b00000, 4'd0);
        rst  = 1'b1;
        req1 = 1'b0;
        tick();
        expect_cyc("rstrun.idle", 5'b00000, 4'd0);

        // len0 changed after grant, non-owner req toggled mid-interval
        req0 = 1'b1;
        len0 = 4'd4;
        tick();
        expect_cyc("lenchg.grant", 5'b10001, 4'd0);
        len0 = 4'd1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            cnt++;
            if (cnt == 1) req1 = 1'b1;
            if (cnt == 3) req1 = 1'b0;
            if (done0 || done1) break;
        end
        check("lenchg.len", cnt, 32'd5);
        expect_cyc("lenchg.done", 5'b10101, 4'd4);
        req0 = 1'b0;
        tick();
        expect_cyc("lenchg.idle", 5'b00000, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter, length and value width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-low (0 = reset).
REQ-004 The block SHALL have port req0, input, 1, requester 0 asks for a timed interval; held high until done0.
REQ-005 The block SHALL have port len0, input, WIDTH, requester 0 terminal count; sampled only at grant.
REQ-006 The block SHALL have port req1, input, 1, requester 1 request, with the same rules as req0.
REQ-007 The block SHALL have port len1, input, WIDTH, requester 1 terminal count; sampled only at grant.
REQ-008 The block SHALL have ports gnt0 and gnt1, output, 1 each, owner of the shared counter.
REQ-009 The block SHALL have ports done0 and done1, output, 1 each, one-cycle completion pulses.
REQ-010 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 The block SHALL have port out, output, WIDTH, current shared counter value.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE, and all outputs SHALL be registered.
REQ-013 IDLE: at an edge with any req high, the FSM SHALL select a winner, latch tc=len of the winner, set out=0, set gnt of the winner=1 and go to RUN; with no req high it SHALL stay in IDLE with out held at 0.
REQ-014 RUN: at each edge, if out==tc the FSM SHALL go to DONE, else out SHALL increment by 1 (unsigned, no wrap possible since tc<=2^WIDTH-1).
REQ-015 DONE: done of the owner SHALL be high for exactly this one cycle and gnt SHALL stay high; the next edge SHALL clear gnt and done and go to IDLE with out=0.
REQ-016 For a length L, gnt SHALL be high for exactly L+2 cycles and done SHALL coincide with the last of them; L=0 SHALL give 1 RUN cycle and 1 DONE cycle.
REQ-017 Abort: if the owner's req is low at an edge in RUN, the FSM SHALL go to IDLE, clear gnt, set out=0 and SHALL NOT issue done.
REQ-018 Changes on len0/len1 after grant, or on the non-owner's req, SHALL NOT affect the active interval.
REQ-019 If the owner's req is still high at the IDLE edge after DONE, the block SHALL re-grant it as a new request; requesters drop req on seeing done.
REQ-020 At most one gnt and at most one done SHALL be high in any cycle.
REQ-021 Simultaneous req0 and req1 in IDLE SHALL be resolved per REQ-025/REQ-026.

Reset
REQ-022 While rst=0 at an edge, the block SHALL set state=IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, out=0, tc=0 and last_owner=1.
REQ-023 Reset asserted during RUN or DONE SHALL take priority: no done pulse, and gnt SHALL be low in the cycle after the edge.
REQ-024 The first IDLE edge with rst=1 SHALL arbitrate normally.

Configuration
REQ-025 With macro COUNTER_SCHED_RR_EN defined, arbitration SHALL be round-robin: on a tie, the requester other than last_owner wins; last_owner SHALL update at every grant.
REQ-026 Without COUNTER_SCHED_RR_EN, arbitration SHALL be fixed priority with req0 always winning ties; last_owner SHALL be unused.

Verification
REQ-027 Bench SHALL cover basic interval: rst low 2 cycles, then req0=1, len0=3 -> gnt0 high 5 cycles, out 0,1,2,3,3, done0 on the 5th cycle only.
REQ-028 Bench SHALL cover zero length: req1=1, len1=0 -> gnt1 high 2 cycles, out=0 throughout, done1 in the 2nd cycle.
REQ-029 Bench SHALL cover a tie: req0=req1=1, len=2 both, held after each done -> without the macro the grants go 0,0,0; with the macro they go 0,1,0.
REQ-030 Bench SHALL cover abort: req0=1, len0=9, req0 dropped when out=4 -> gnt0 low the next cycle, out=0, done0 never high, busy=0.
REQ-031 Bench SHALL cover reset mid-run: req1=1, len1=15, rst=0 when out=7 -> next cycle gnt1=0, out=0, done1=0, state IDLE.
REQ-032 Bench SHALL cover len change after grant: len0=4 at grant changed to 1 during RUN -> the interval still ends at out=4 with done0 high.
